// File: rtl/add64_word_seq_pkg.sv
// Shared constants and FSM state type for the add64_word_seq word sequencer.
//   WORD_W : stream beat width
//   ADD_W  : adder core width (must equal 2*WORD_W)
//   state_t: sequencer states, 3-bit encoding
package add64_word_seq_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADD_W  = 64;

  typedef enum logic [2:0] {
    LD_A0  = 3'd0,
    LD_A1  = 3'd1,
    LD_B0  = 3'd2,
    LD_B1  = 3'd3,
    CALC   = 3'd4,
    OUT_LO = 3'd5,
    OUT_HI = 3'd6
  } state_t;

endpackage

// File: rtl/add64_word_seq_if.sv
// Word-stream interface for add64_word_seq.
//   in_valid/in_ready/in_data/in_sop/in_cin : operand beat stream (into block)
//   out_valid/out_ready/out_data/out_last/out_carry : sum beat stream (out of block)
// Modports:
//   slave  : the add64_word_seq block itself
//   master : the system side that feeds operands and consumes sums
interface add64_word_seq_if #(
  parameter int unsigned WORD_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_sop;
  logic              in_cin;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_carry;

  modport slave (
    input  in_valid, in_data, in_sop, in_cin, out_ready,
    output in_ready, out_valid, out_data, out_last, out_carry
  );

  modport master (
    output in_valid, in_data, in_sop, in_cin, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_carry
  );

endinterface

// File: rtl/sixtyfourbit.sv
// 64-bit adder core: sum = a + b + cin, cout is the 65th bit.
//   a, b : operands
//   cin  : carry-in
//   sum  : 64-bit sum modulo 2^64
//   cout : carry-out
module sixtyfourbit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/add64_word_seq.sv
// Sequencer that collects A_lo, A_hi, B_lo, B_hi (+carry-in) as 32-bit beats,
// runs them through the 64-bit adder core for one cycle, then returns the sum
// as a low beat followed by a high beat (with carry-out).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result streams (slave modport)
//   busy       : high whenever the sequencer is not idle in LD_A0
//   op_count   : completed operations, wraps
module add64_word_seq
  import add64_word_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  add64_word_seq_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t             r_state;
  state_t             w_next;
  logic [ADD_W-1:0]   r_a;
  logic [ADD_W-1:0]   r_b;
  logic               r_cin;
  logic [ADD_W-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_op_count;
  logic [ADD_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_in_xfer;
  logic               w_out_xfer;

  assign w_in_xfer  = bus.in_valid  & bus.in_ready;
  assign w_out_xfer = bus.out_valid & bus.out_ready;

  sixtyfourbit u_add (
    .a    (r_a),
    .b    (r_b),
    .cin  (r_cin),
    .sum  (w_sum),
    .cout (w_carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LD_A0;
    else        r_state <= w_next;
  end

  // Next-state logic; an sop beat in any later load state restarts at A_hi
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LD_A0:  if (w_in_xfer) w_next = LD_A1;
      LD_A1:  if (w_in_xfer) w_next = (bus.in_sop) ? LD_A1 : LD_B0;
      LD_B0:  if (w_in_xfer) w_next = (bus.in_sop) ? LD_A1 : LD_B1;
      LD_B1:  if (w_in_xfer) w_next = (bus.in_sop) ? LD_A1 : CALC;
      CALC:   w_next = OUT_LO;
      OUT_LO: if (w_out_xfer) w_next = OUT_HI;
      OUT_HI: if (w_out_xfer) w_next = LD_A0;
      default: w_next = LD_A0;
    endcase
  end

  // Outputs decoded from state and result registers only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_carry = 1'b0;
    busy          = (r_state != LD_A0);
    unique case (r_state)
      LD_A0, LD_A1, LD_B0, LD_B1: bus.in_ready = 1'b1;
      OUT_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_sum[WORD_W-1:0];
      end
      OUT_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_sum[2*WORD_W-1:WORD_W];
        bus.out_last  = 1'b1;
        bus.out_carry = r_carry;
      end
      default: ;
    endcase
  end

  // Operand, result and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_op_count <= '0;
    end else begin
      unique case (r_state)
        LD_A0, LD_A1, LD_B0, LD_B1: begin
          if (w_in_xfer) begin
            if (r_state == LD_A0 || bus.in_sop) begin
              r_a[WORD_W-1:0] <= bus.in_data;
              r_cin           <= bus.in_cin;
            end else begin
              unique case (r_state)
                LD_A1:   r_a[2*WORD_W-1:WORD_W] <= bus.in_data;
                LD_B0:   r_b[WORD_W-1:0]        <= bus.in_data;
                default: r_b[2*WORD_W-1:WORD_W] <= bus.in_data;
              endcase
            end
          end
        end
        CALC: begin
          r_sum   <= w_sum;
          r_carry <= w_carry;
        end
        OUT_HI: if (w_out_xfer) r_op_count <= r_op_count + 1'b1;
        default: ;
      endcase
    end
  end

  assign op_count = r_op_count;

endmodule

// File: tb/tb_add64_word_seq.sv
module tb_add64_word_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ops = 0;

  add64_word_seq_if #(.WORD_W(32)) bus ();

  add64_word_seq #(.WORD_W(32), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        co;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic cin,
                           input int unsigned gap);
    int unsigned n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_cin   = cin;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready wait: got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_cin   = 1'b0;
  endtask

  task automatic recv_beat(output logic [31:0] d, output logic last, output logic co,
                           output logic rdy_before);
    int unsigned n;
    @(negedge clk);
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid wait: got 0 expected 1 within 50 cycles");
    end
    d          = bus.out_data;
    last       = bus.out_last;
    co         = bus.out_carry;
    rdy_before = bus.in_ready;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic recv_result(input string nm, input logic [31:0] lo, input logic [31:0] hi,
                             input logic co, input logic chk_ready);
    logic [31:0] d;
    logic        last, c, rdy;
    recv_beat(d, last, c, rdy);
    chk({nm, " lo data"}, d, lo);
    chk({nm, " lo last"}, last, 1'b0);
    chk({nm, " lo carry"}, c, 1'b0);
    recv_beat(d, last, c, rdy);
    exp_ops++;
    chk({nm, " hi data"}, d, hi);
    chk({nm, " hi last"}, last, 1'b1);
    chk({nm, " hi carry"}, c, co);
    @(negedge clk);
    chk({nm, " op_count"}, op_count, exp_ops[15:0]);
    if (chk_ready) begin
      chk({nm, " in_ready during OUT_HI"}, rdy, 1'b0);
      chk({nm, " in_ready after OUT_HI"}, bus.in_ready, 1'b1);
    end
  endtask

  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [31:0] lo, input logic [31:0] hi,
                        input logic co, input int unsigned gmax);
    send_beat(a[31:0],  1'b1, cin,  $urandom_range(gmax, 0));
    send_beat(a[63:32], 1'b0, 1'b0, $urandom_range(gmax, 0));
    send_beat(b[31:0],  1'b0, 1'b0, $urandom_range(gmax, 0));
    send_beat(b[63:32], 1'b0, 1'b0, $urandom_range(gmax, 0));
    recv_result(nm, lo, hi, co, gmax != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[6];
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] rs;

    vecs[0] = '{64'h00000000_FFFFFFFF, 64'h1, 1'b0, 32'h00000000, 32'h00000001, 1'b0};
    vecs[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 32'h00000000, 32'h00000000, 1'b1};
    vecs[2] = '{64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0,
                32'h22222211, 32'h22222222, 1'b0};
    vecs[3] = '{64'h80000000_00000000, 64'h80000000_00000000, 1'b0,
                32'h00000000, 32'h00000000, 1'b1};
    vecs[4] = '{64'h0, 64'h0, 1'b1, 32'h00000001, 32'h00000000, 1'b0};
    vecs[5] = '{64'h7FFFFFFF_FFFFFFFF, 64'h0, 1'b1, 32'h00000000, 32'h80000000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sop    = 1'b0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst in_ready",  bus.in_ready,  1'b1);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_data",  bus.out_data,  32'h0);
    chk("rst out_last",  bus.out_last,  1'b0);
    chk("rst out_carry", bus.out_carry, 1'b0);
    chk("rst busy",      busy,          1'b0);
    chk("rst op_count",  op_count,      16'h0);
    rst_n = 1'b1;

    // Table-driven operations, no gaps
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].lo, vecs[i].hi, vecs[i].co, 0);
    end

    // Latency and output backpressure
    send_beat(32'h9ABCDEF0, 1'b1, 1'b0, 0);
    send_beat(32'h12345678, 1'b0, 1'b0, 0);
    send_beat(32'h87654321, 1'b0, 1'b0, 0);
    send_beat(32'h0FEDCBA9, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("calc out_valid", bus.out_valid, 1'b0);
    chk("calc busy",      busy,          1'b1);
    chk("calc in_ready",  bus.in_ready,  1'b0);
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("stall%0d out_data", i),  bus.out_data,  32'h22222211);
      chk($sformatf("stall%0d out_last", i),  bus.out_last,  1'b0);
      chk($sformatf("stall%0d in_ready", i),  bus.in_ready,  1'b0);
      chk($sformatf("stall%0d busy", i),      busy,          1'b1);
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    recv_result("stall", 32'h22222211, 32'h22222222, 1'b0, 1'b1);

    // Resync on sop mid-operand
    send_beat(32'h11, 1'b1, 1'b0, 0);
    send_beat(32'h22, 1'b0, 1'b0, 0);
    send_beat(32'h5,  1'b1, 1'b1, 0);
    send_beat(32'h0,  1'b0, 1'b0, 0);
    send_beat(32'h3,  1'b0, 1'b0, 0);
    send_beat(32'h0,  1'b0, 1'b0, 0);
    recv_result("resync", 32'h9, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset after B_lo
    send_beat(32'hAAAA0000, 1'b1, 1'b1, 0);
    send_beat(32'h5555FFFF, 1'b0, 1'b0, 0);
    send_beat(32'h12345678, 1'b0, 1'b0, 0);
    chk("pre-rst busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst in_ready",  bus.in_ready,  1'b1);
    chk("async rst out_valid", bus.out_valid, 1'b0);
    chk("async rst out_data",  bus.out_data,  32'h0);
    chk("async rst busy",      busy,          1'b0);
    chk("async rst op_count",  op_count,      16'h0);
    exp_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-rst", 64'h2, 64'h3, 1'b0, 32'h5, 32'h0, 1'b0, 0);

    // Back-to-back operations with random input gaps against a reference sum
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(1, 0));
      rs = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      run_op($sformatf("b2b%0d", i), ra, rb, rc, rs[31:0], rs[63:32], rs[64], 3);
    end
    chk("final op_count", op_count, 16'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
